// File: rtl/transmitter_4phase.sv
// -----------------------------------------------------------------------------
// transmitter_4phase
//
// Sending end of the four-phase bundled-data link between cores. One word is
// accepted from the local core per handshake and driven onto the inter-core
// data bus. After a programmable setup delay, req is raised. The remote ack is
// brought into the clk domain through two flops. The transmitter returns to
// idle only once the synchronized ack has fallen again.
//
// Parameters
//   DATA_WIDTH   : width of the data bus
//   SETUP_CYCLES : cycles output_tx is stable before req rises (1..15)
//   TIMEOUT      : cycles allowed in an ack-wait state before err sets
//                  (0 disables, 1..65535)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   valid     in   local core offers input_tx
//   input_tx  in   word to send
//   ready     out  a word can be accepted this cycle (combinational)
//   ack       in   acknowledge from the remote receiver, asynchronous to clk
//   req       out  request to the remote receiver, registered
//   output_tx out  data bus to the remote core, registered
//   done      out  one-cycle pulse when a handshake has fully completed
//   err       out  sticky flag: ack-wait timeout or spurious ack
// -----------------------------------------------------------------------------
module transmitter_4phase #(
   parameter int DATA_WIDTH   = 8,
   parameter int SETUP_CYCLES = 2,
   parameter int TIMEOUT      = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] input_tx,
   output logic                  ready,
   input  logic                  ack,
   output logic                  req,
   output logic [DATA_WIDTH-1:0] output_tx,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_REQ,
      ST_RELEASE
   } state_t;

   localparam logic [3:0]  SETUP_LOAD  = 4'(SETUP_CYCLES);
   localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);
   localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

   state_t                  r_state;
   logic                    r_ack_a1;
   logic                    r_ack_a2;
   logic [3:0]              r_setup_cnt;
   logic [15:0]             r_wait_cnt;
   logic                    r_req;
   logic [DATA_WIDTH-1:0]   r_data;
   logic                    r_done;
   logic                    r_err;

   logic [15:0]             w_wait_next;
   logic                    w_timeout_hit;
   logic                    w_ack_s;

   // Only the second synchronizer stage is ever looked at by the FSM.
   assign w_ack_s = r_ack_a2;

   // The wait counter sticks at all-ones instead of wrapping, so a very long
   // stall can never alias back onto a small TIMEOUT value.
   assign w_wait_next   = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + 16'd1;

   // err is raised on the edge where the counter reaches TIMEOUT, so it is
   // visible exactly TIMEOUT cycles after the wait state was entered.
   assign w_timeout_hit = TIMEOUT_EN && (w_wait_next == TIMEOUT_VAL);

   // ready gates itself with reset so the local core cannot hand over a word
   // on the same edge that reset is wiping the datapath.
   assign ready     = (r_state == ST_IDLE) && !reset;
   assign req       = r_req;
   assign output_tx = r_data;
   assign done      = r_done;
   assign err       = r_err;

   // NOTE: every register in this block is assigned with <= so all of them
   // update together from the values present before the edge; with = the
   // synchronizer would collapse into a single flop and the FSM would see
   // half-updated state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ack_a1    <= 1'b0;
         r_ack_a2    <= 1'b0;
         r_setup_cnt <= '0;
         r_wait_cnt  <= '0;
         r_req       <= 1'b0;
         // NOTE: the data register is reset as well, not just the control
         // state, because the bus must read zero after an abandoned transfer.
         r_data      <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_ack_a1 <= ack;
         r_ack_a2 <= r_ack_a1;
         r_done   <= 1'b0;

         // An ack while nothing is outstanding is flagged, but otherwise
         // does not disturb the FSM.
         if (w_ack_s && (r_state == ST_IDLE || r_state == ST_SETUP)) begin
            r_err <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               // In this branch reset is low, so ready is already 1.
               if (valid) begin
                  r_data      <= input_tx;
                  r_setup_cnt <= SETUP_LOAD;
                  r_state     <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               // The load value counts as the first setup cycle, so leaving
               // on a count of 1 raises req exactly SETUP_CYCLES edges after
               // acceptance. The <= also guards an illegal load of 0.
               if (r_setup_cnt <= 4'd1) begin
                  r_req      <= 1'b1;
                  r_wait_cnt <= '0;
                  r_state    <= ST_REQ;
               end else begin
                  r_setup_cnt <= r_setup_cnt - 4'd1;
               end
            end

            ST_REQ: begin
               if (w_ack_s) begin
                  r_req      <= 1'b0;
                  r_wait_cnt <= '0;
                  r_state    <= ST_RELEASE;
               end else begin
                  r_wait_cnt <= w_wait_next;
                  if (w_timeout_hit) begin
                     r_err <= 1'b1;
                  end
               end
            end

            ST_RELEASE: begin
               if (!w_ack_s) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_wait_cnt <= w_wait_next;
                  if (w_timeout_hit) begin
                     r_err <= 1'b1;
                  end
               end
            end

            default: begin
               r_req   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transmitter_4phase.sv
// -----------------------------------------------------------------------------
// tb_transmitter_4phase
//
// Directed bench for transmitter_4phase (DATA_WIDTH=8, SETUP_CYCLES=2,
// TIMEOUT=10). Inputs change on the falling edge, and outputs are sampled 1 ns
// after the rising edge. Each table row therefore describes one rising edge:
// the inputs present at that edge and the outputs expected right after it.
// -----------------------------------------------------------------------------
module tb_transmitter_4phase;

   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic          valid;
   logic [DW-1:0] input_tx;
   logic          ready;
   logic          ack;
   logic          req;
   logic [DW-1:0] output_tx;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_err    = 0;

   transmitter_4phase #(
      .DATA_WIDTH  (DW),
      .SETUP_CYCLES(2),
      .TIMEOUT     (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .valid    (valid),
      .input_tx (input_tx),
      .ready    (ready),
      .ack      (ack),
      .req      (req),
      .output_tx(output_tx),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   typedef struct {
      logic          valid;
      logic [DW-1:0] data;
      logic          ack;
      logic          ready;
      logic          req;
      logic [DW-1:0] tx;
      logic          done;
      logic          err;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic v, logic [DW-1:0] d, logic a,
                               logic rdy, logic rq, logic [DW-1:0] tx,
                               logic dn, logic er);
      vec_t r;
      r.valid = v;   r.data = d;  r.ack  = a;
      r.ready = rdy; r.req  = rq; r.tx   = tx;
      r.done  = dn;  r.err  = er;
      return r;
   endfunction

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] words[3];
   logic          accept_now;
   logic          prev_done;
   logic          prev_req;
   logic [DW-1:0] prev_tx;
   int            n_acc;
   int            n_done;

   initial begin
      //               v  data   ack  rdy req tx     done err
      vecs[0]  = mk(1, 8'hA5, 0,   0,  0,  8'hA5, 0,   0); // accept E0
      vecs[1]  = mk(0, 8'h00, 0,   0,  0,  8'hA5, 0,   0);
      vecs[2]  = mk(0, 8'h00, 0,   0,  1,  8'hA5, 0,   0); // req at E0+2
      vecs[3]  = mk(0, 8'h00, 1,   0,  1,  8'hA5, 0,   0); // ack sampled (A)
      vecs[4]  = mk(0, 8'h00, 1,   0,  1,  8'hA5, 0,   0);
      vecs[5]  = mk(0, 8'h00, 1,   0,  0,  8'hA5, 0,   0); // req falls A+2
      vecs[6]  = mk(0, 8'h00, 0,   0,  0,  8'hA5, 0,   0); // ack low (B)
      vecs[7]  = mk(0, 8'h00, 0,   0,  0,  8'hA5, 0,   0);
      vecs[8]  = mk(0, 8'h00, 0,   1,  0,  8'hA5, 1,   0); // done after B+2
      vecs[9]  = mk(0, 8'h00, 0,   1,  0,  8'hA5, 0,   0);
      vecs[10] = mk(1, 8'h3C, 0,   0,  0,  8'h3C, 0,   0); // accept 0x3C
      vecs[11] = mk(1, 8'hFF, 0,   0,  0,  8'h3C, 0,   0); // ignored (SETUP)
      vecs[12] = mk(0, 8'h00, 0,   0,  1,  8'h3C, 0,   0);
      vecs[13] = mk(1, 8'hFF, 1,   0,  1,  8'h3C, 0,   0); // ignored (REQ)
      vecs[14] = mk(0, 8'h00, 1,   0,  1,  8'h3C, 0,   0);
      vecs[15] = mk(1, 8'hFF, 1,   0,  0,  8'h3C, 0,   0);
      vecs[16] = mk(1, 8'hFF, 0,   0,  0,  8'h3C, 0,   0); // ignored (RELEASE)
      vecs[17] = mk(0, 8'h00, 0,   0,  0,  8'h3C, 0,   0);
      vecs[18] = mk(0, 8'h00, 0,   1,  0,  8'h3C, 1,   0);
      vecs[19] = mk(0, 8'h00, 0,   1,  0,  8'h3C, 0,   0);

      words[0] = 8'h01;
      words[1] = 8'h02;
      words[2] = 8'h03;

      // ---------------- reset values ----------------
      reset    = 1'b1;
      valid    = 1'b0;
      input_tx = '0;
      ack      = 1'b0;
      edge_sample();
      edge_sample();
      check("rst_ready", ready, 0);
      check("rst_req", req, 0);
      check("rst_tx", output_tx, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_ready_after_release", ready, 1);

      // ---------------- single word and ignored valid: table ----------------
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         valid    = vecs[i].valid;
         input_tx = vecs[i].data;
         ack      = vecs[i].ack;
         edge_sample();
         check($sformatf("vec%0d_ready", i), ready, vecs[i].ready);
         check($sformatf("vec%0d_req", i), req, vecs[i].req);
         check($sformatf("vec%0d_tx", i), output_tx, vecs[i].tx);
         check($sformatf("vec%0d_done", i), done, vecs[i].done);
         check($sformatf("vec%0d_err", i), err, vecs[i].err);
      end

      // ---------------- back-to-back with an instant receiver ----------------
      n_acc     = 0;
      n_done    = 0;
      prev_done = 1'b0;
      prev_req  = req;
      prev_tx   = output_tx;
      valid     = 1'b1;
      input_tx  = words[0];
      for (int cyc = 0; cyc < 200 && n_done < 3; cyc++) begin
         @(negedge clk);
         ack        = req;
         accept_now = valid && ready;
         if (prev_done && n_acc < 3)
            check("b2b_accept_in_done", accept_now, 1);
         edge_sample();
         if (accept_now) begin
            check($sformatf("b2b_capture%0d", n_acc), output_tx, words[n_acc]);
            n_acc++;
            if (n_acc < 3) begin
               input_tx = words[n_acc];
            end else begin
               valid    = 1'b0;
               input_tx = '0;
            end
         end
         if (req && prev_req)
            check("b2b_tx_stable", output_tx, prev_tx);
         if (done) begin
            n_done++;
            check("b2b_ready_in_done", ready, 1);
         end
         prev_done = done;
         prev_req  = req;
         prev_tx   = output_tx;
      end
      check("b2b_done_count", n_done, 3);
      check("b2b_accept_count", n_acc, 3);
      check("b2b_err", err, 0);
      check("b2b_last_word", output_tx, 8'h03);
      @(negedge clk);
      ack = 1'b0;

      // ---------------- timeout, then late ack ----------------
      @(negedge clk);
      valid    = 1'b1;
      input_tx = 8'h5A;
      edge_sample(); // E0
      check("to_accept_tx", output_tx, 8'h5A);
      @(negedge clk);
      valid    = 1'b0;
      input_tx = 8'hFF;
      for (int k = 1; k <= 21; k++) begin
         if (k > 1) @(negedge clk);
         ack = (k >= 15 && k <= 17);
         edge_sample();
         check($sformatf("to_k%0d_req", k), req, (k >= 2 && k <= 16));
         check($sformatf("to_k%0d_err", k), err, (k >= 12));
         check($sformatf("to_k%0d_done", k), done, (k == 20));
         check($sformatf("to_k%0d_ready", k), ready, (k >= 20));
         check($sformatf("to_k%0d_tx", k), output_tx, 8'h5A);
      end

      // ---------------- spurious ack in IDLE ----------------
      @(negedge clk);
      reset = 1'b1;
      edge_sample();
      check("sp_reset_err", err, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(negedge clk);
         ack = (k <= 3);
         edge_sample();
         check($sformatf("sp_k%0d_err", k), err, (k >= 3));
         check($sformatf("sp_k%0d_req", k), req, 0);
         check($sformatf("sp_k%0d_ready", k), ready, 1);
         check($sformatf("sp_k%0d_tx", k), output_tx, 0);
      end

      // ---------------- reset one cycle after req rises ----------------
      @(negedge clk);
      ack      = 1'b0;
      valid    = 1'b1;
      input_tx = 8'h77;
      edge_sample(); // E0
      @(negedge clk);
      valid = 1'b0;
      edge_sample(); // E0+1
      @(negedge clk);
      edge_sample(); // E0+2
      check("mr_req_up", req, 1);
      check("mr_tx", output_tx, 8'h77);
      @(negedge clk);
      reset = 1'b1;
      edge_sample(); // E0+3, reset sampled
      check("mr_req_dropped", req, 0);
      check("mr_tx_cleared", output_tx, 0);
      check("mr_err_cleared", err, 0);
      check("mr_no_done", done, 0);
      check("mr_ready_in_reset", ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mr_ready_after_release", ready, 1);
      for (int k = 0; k < 4; k++) begin
         edge_sample();
         check($sformatf("mr_post%0d_req", k), req, 0);
         check($sformatf("mr_post%0d_done", k), done, 0);
         check($sformatf("mr_post%0d_ready", k), ready, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/transmitter_4phase.md
# transmitter_4phase

Sending end of the two-flop-synchronized, four-phase bundled-data link between cores. Accepts one word per handshake from the local core, drives it onto the inter-core data bus, raises `req` after a programmable setup delay, synchronizes the remote `ack` through two flip-flops, and returns to idle only after `ack` has fallen. It is the transmit counterpart of the existing receiver on the same req/ack/data wires.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the data bus
- SETUP_CYCLES, 2, cycles `output_tx` is stable before `req` rises; legal range 1..15
- TIMEOUT, 255, cycles allowed in either ack-wait state before `err` sets; 0 disables; legal range 0..65535

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- valid  input  1  local core offers `input_tx`
- input_tx  input  DATA_WIDTH  word to send
- ready  output  1  transmitter can accept a word this cycle
- ack  input  1  acknowledge from the remote receiver, asynchronous to `clk`
- req  output  1  request to the remote receiver, registered
- output_tx  output  DATA_WIDTH  data bus to the remote core, registered
- done  output  1  one-cycle pulse: handshake fully completed
- err  output  1  sticky: timeout or spurious ack

## Operation
- `ack` passes through two reset-cleared flops (a1, a2). The FSM uses only a2 (ack_s).
- States: IDLE, SETUP, REQ, RELEASE.
- IDLE: `ready`=1. On `valid`&`ready`, capture `input_tx` into `output_tx`, load setup counter with SETUP_CYCLES, go to SETUP. `valid` while not ready is ignored; `input_tx` is never sampled outside this acceptance.
- SETUP: `req`=0; counter decrements each cycle; when it reaches 1, go to REQ and assert `req`.
- REQ: `req`=1; wait for ack_s=1, then deassert `req` and go to RELEASE.
- RELEASE: `req`=0; wait for ack_s=0, then pulse `done`, go to IDLE.
- `output_tx` holds the captured word until the next acceptance; never changes while `req`=1.
- Timeout: a 16-bit wait counter clears on entry to REQ and to RELEASE, and increments each cycle in those states, saturating. When it equals TIMEOUT (TIMEOUT≠0), `err` sets. The FSM keeps waiting; there is no abort.
- Spurious ack: ack_s=1 while in IDLE or SETUP sets `err`. The ack is otherwise ignored. While ack_s stays high, SETUP may still advance to REQ; REQ then completes the normal way.
- `err` clears only on reset.
- `ready` = (state==IDLE) & !reset, combinational.

## Timing
- Reset values: `req`=0, `output_tx`=0, `done`=0, `err`=0, a1=a2=0, state IDLE, counters 0. `ready`=0 while reset is high and 1 in the first cycle after reset falls.
- Reset mid-transfer: on the next edge `req` drops, `output_tx` clears, `done` is not pulsed, and any remote handshake is abandoned.
- Acceptance edge E0 (`valid`&`ready` sampled high): `output_tx` is valid after E0, and `req` rises at edge E0+SETUP_CYCLES.
- `ack` first sampled high at edge A: a2 is high after A+1, and `req` falls at edge A+2.
- `ack` first sampled low at edge B: `done`=1 for exactly the cycle after edge B+2; `ready`=1 in that same cycle; a `valid` in that cycle is accepted.
- Minimum transfer with an instant receiver: SETUP_CYCLES + 2 + 2 + ack latency cycles.

## Test plan
- Single word, DATA_WIDTH=8, SETUP_CYCLES=2, `input_tx`=0xA5; bench raises `ack` 1 cycle after `req`, drops it 1 cycle after `req` falls -> `req` rises at E0+2, falls 3 edges after `ack` rises; one `done` pulse; `output_tx`=0xA5 throughout; `err`=0.
- Back-to-back: `valid` held high with words 0x01, 0x02, 0x03 -> three complete handshakes in order; each word accepted in its `done` cycle; `output_tx` never changes while `req`=1.
- `valid` pulsed during SETUP/REQ/RELEASE with 0xFF -> ignored; `output_tx` keeps the earlier word; no extra `done`.
- TIMEOUT=10, `ack` never rises -> `err` sets 10 cycles after entering REQ; `req` stays 1; a late `ack` still completes with `done`; `err` remains 1.
- Spurious `ack` pulse of 3 cycles in IDLE -> `err`=1, `req` stays 0, no state change.
- Reset asserted one cycle after `req` rises -> next edge: `req`=0, `output_tx`=0, `err`=0, no `done`; `ready`=1 in the first cycle after reset falls.
